// File: rtl/shift_pipe_pkg.sv
// Shared opcode encoding and reserved-opcode check for the pipelined shifter.
// Rotates are only legal when SHIFT_PIPE_ROTATE_EN is defined.
package shift_pipe_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_SLL = 3'd0;
    localparam op_t OP_SRL = 3'd1;
    localparam op_t OP_SRA = 3'd2;
    localparam op_t OP_ROL = 3'd3;
    localparam op_t OP_ROR = 3'd4;

    function automatic logic is_reserved(input op_t op);
`ifdef SHIFT_PIPE_ROTATE_EN
        return op > OP_ROR;
`else
        return op > OP_SRA;
`endif
    endfunction

endpackage

// File: rtl/shift_stage.sv
// Purpose: one combinational step of the shifter, moves data by STEP when en is set.
// Latency: combinational. Backpressure: none, the parent owns the registers.
// Rotate cases exist only under SHIFT_PIPE_ROTATE_EN; otherwise 011/100 pass through.
module shift_stage
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic [2:0]       op,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = data;
        if (en) begin
            case (op)
                OP_SLL:  res = {data[WIDTH-1-STEP:0], {STEP{1'b0}}};
                OP_SRL:  res = {{STEP{1'b0}}, data[WIDTH-1:STEP]};
                OP_SRA:  res = {{STEP{data[WIDTH-1]}}, data[WIDTH-1:STEP]};
`ifdef SHIFT_PIPE_ROTATE_EN
                OP_ROL:  res = {data[WIDTH-1-STEP:0], data[WIDTH-1:WIDTH-STEP]};
                OP_ROR:  res = {data[STEP-1:0], data[WIDTH-1:STEP]};
`endif
                default: res = data;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Purpose: pipelined barrel shifter/rotator, one amount bit resolved per stage (rotates: SHIFT_PIPE_ROTATE_EN).
// Latency: SHAMT_W cycles, one op per cycle. Backpressure: out_valid && !out_ready freezes every stage.
// Flush clears all valids at the next edge and blocks input in the same cycle.
module shift_pipe
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [WIDTH-1:0]   in_src,
    input  logic [SHAMT_W-1:0] in_amt,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_res,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_err
);

    logic               stall;
    logic [SHAMT_W-1:0] vld_q;
    logic [WIDTH-1:0]   dat_q [SHAMT_W];
    logic [2:0]         op_q  [SHAMT_W];
    logic [TAG_W-1:0]   tag_q [SHAMT_W];
    logic [SHAMT_W-1:0] amt_q [SHAMT_W];

    logic [SHAMT_W-1:0] st_vld;
    logic [WIDTH-1:0]   st_dat [SHAMT_W];
    logic [WIDTH-1:0]   st_res [SHAMT_W];
    logic [2:0]         st_op  [SHAMT_W];
    logic [TAG_W-1:0]   st_tag [SHAMT_W];
    logic [SHAMT_W-1:0] st_amt [SHAMT_W];

    assign stall    = vld_q[SHAMT_W-1] && !out_ready;
    assign in_ready = !stall && !flush;

    // Amount travels right-aligned: each stage consumes bit 0 and shifts the rest down.
    always_comb begin
        st_vld[0] = in_valid && in_ready;
        st_dat[0] = in_src;
        st_op[0]  = in_op;
        st_tag[0] = in_tag;
        st_amt[0] = in_amt;
        for (int k = 1; k < SHAMT_W; k++) begin
            st_vld[k] = vld_q[k-1];
            st_dat[k] = dat_q[k-1];
            st_op[k]  = op_q[k-1];
            st_tag[k] = tag_q[k-1];
            st_amt[k] = amt_q[k-1];
        end
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .STEP  (1 << k)
        ) u_shift (
            .op   (st_op[k]),
            .en   (st_amt[k][0]),
            .data (st_dat[k]),
            .res  (st_res[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < SHAMT_W; k++) begin
                dat_q[k] <= '0;
                op_q[k]  <= '0;
                tag_q[k] <= '0;
                amt_q[k] <= '0;
            end
        end else if (flush) begin
            vld_q <= '0;
        end else if (!stall) begin
            vld_q <= st_vld;
            for (int k = 0; k < SHAMT_W; k++) begin
                dat_q[k] <= st_res[k];
                op_q[k]  <= st_op[k];
                tag_q[k] <= st_tag[k];
                amt_q[k] <= st_amt[k] >> 1;
            end
        end
    end

    logic unused_amt;
    assign unused_amt = ^amt_q[SHAMT_W-1];

    assign out_valid = vld_q[SHAMT_W-1];
    assign out_res   = dat_q[SHAMT_W-1];
    assign out_tag   = tag_q[SHAMT_W-1];
    assign out_err   = is_reserved(op_q[SHAMT_W-1]);

endmodule

// File: tb/tb_shift_pipe.sv
// Directed and random checks of shift_pipe (WIDTH=16) against an arithmetic reference model.
module tb_shift_pipe;

    localparam int W  = 16;
    localparam int TW = 4;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [W-1:0]  in_src;
    logic [SW-1:0] in_amt;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_res;
    logic [TW-1:0] out_tag;
    logic          out_err;

    always #5 clk = ~clk;

    shift_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_src    (in_src),
        .in_amt    (in_amt),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_out = 0;
    int          n_stall = 0;
    int          last_cyc = 0;
    int          acc_cyc = 0;
    logic        last_acc = 1'b0;
    logic [15:0] last_res;
    logic [3:0]  last_tag;
    logic        last_err;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_res;
    logic [3:0]  prev_tag;
    logic        prev_err;

    function automatic logic rsv(input logic [2:0] op);
`ifdef SHIFT_PIPE_ROTATE_EN
        return op >= 3'd5;
`else
        return op >= 3'd3;
`endif
    endfunction

    // Shifts as multiply/divide by 2^amt, rotates as a doubled-word window.
    function automatic logic [15:0] ref_shift(input logic [2:0] op, input logic [15:0] src,
                                              input logic [3:0] amt);
        int          p;
        int          s;
        int          qv;
        logic [31:0] d;
        p = 1 << amt;
        if (rsv(op)) return src;
        case (op)
            3'd0: return 16'((int'(src) * p) % 65536);
            3'd1: return 16'(int'(src) / p);
            3'd2: begin
                s  = int'($signed(src));
                qv = s / p;
                if ((s % p) != 0 && s < 0) qv = qv - 1;
                return 16'(qv);
            end
            3'd3: begin
                d = {src, src} << amt;
                return d[31:16];
            end
            default: begin
                d = {src, src} >> amt;
                return d[15:0];
            end
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, expv);
        end
    endtask

    // One clock cycle: drive after negedge, sample 1ns later, scoreboard on handshakes.
    task automatic step(input logic v, input logic [2:0] op, input logic [15:0] src,
                        input logic [3:0] amt, input logic [3:0] tag,
                        input logic ordy, input logic fl);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_op     = op;
        in_src    = src;
        in_amt    = amt;
        in_tag    = tag;
        out_ready = ordy;
        flush     = fl;
        #1;
        cyc++;
        chk("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !ordy) && !fl});
        if (prev_stall) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_res", {16'd0, out_res}, {16'd0, prev_res});
            chk("hold_tag", {28'd0, out_tag}, {28'd0, prev_tag});
            chk("hold_err", {31'd0, out_err}, {31'd0, prev_err});
        end
        if (out_valid && ordy) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("res", {16'd0, out_res}, {16'd0, e.res});
                chk("tag", {28'd0, out_tag}, {28'd0, e.tag});
                chk("err", {31'd0, out_err}, {31'd0, e.err});
            end
            n_out++;
            last_cyc = cyc;
            last_res = out_res;
            last_tag = out_tag;
            last_err = out_err;
        end
        if (out_valid && !ordy) n_stall++;
        last_acc = v && in_ready;
        if (fl) sb.delete();
        if (last_acc) begin
            e.res = ref_shift(op, src, amt);
            e.tag = tag;
            e.err = rsv(op);
            sb.push_back(e);
            acc_cyc = cyc;
        end
        prev_stall = out_valid && !ordy && !fl;
        prev_res   = out_res;
        prev_tag   = out_tag;
        prev_err   = out_err;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 3'd0, 16'd0, 4'd0, 4'd0, ordy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) idle(1'b1);
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    task automatic run_one(input string name, input logic [2:0] op, input logic [15:0] src,
                           input logic [3:0] amt, input logic [15:0] exp_res, input logic exp_err);
        int n0;
        n0 = n_out;
        step(1'b1, op, src, amt, 4'hA, 1'b1, 1'b0);
        chk({name, "_accept"}, {31'd0, last_acc}, 32'd1);
        for (int i = 0; i < 16 && n_out == n0; i++) idle(1'b1);
        chk({name, "_count"}, n_out - n0, 32'd1);
        chk({name, "_latency"}, last_cyc - acc_cyc, 32'd4);
        chk({name, "_res"}, {16'd0, last_res}, {16'd0, exp_res});
        chk({name, "_tag"}, {28'd0, last_tag}, 32'hA);
        chk({name, "_err"}, {31'd0, last_err}, {31'd0, exp_err});
    endtask

    logic [2:0]  op_a  [8];
    logic [15:0] src_a [8];
    logic [3:0]  amt_a [8];
    logic        ordy;
    int          idx;
    int          n0;

    initial begin
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 3'd0;
        in_src = '0; in_amt = '0; in_tag = '0; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_res", {16'd0, out_res}, 32'd0);
        chk("reset_tag", {28'd0, out_tag}, 32'd0);
        chk("reset_err", {31'd0, out_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        run_one("sll15", 3'd0, 16'h0001, 4'd15, 16'h8000, 1'b0);
        run_one("sra3", 3'd2, 16'h8000, 4'd3, 16'hF000, 1'b0);
        run_one("srl3", 3'd1, 16'h8000, 4'd3, 16'h1000, 1'b0);
`ifdef SHIFT_PIPE_ROTATE_EN
        run_one("ror4", 3'd4, 16'h1234, 4'd4, 16'h4123, 1'b0);
        run_one("rol4", 3'd3, 16'h1234, 4'd4, 16'h2341, 1'b0);
`else
        run_one("ror4", 3'd4, 16'h1234, 4'd4, 16'h1234, 1'b1);
        run_one("rol4", 3'd3, 16'h1234, 4'd4, 16'h1234, 1'b1);
`endif
        run_one("rsv110", 3'd6, 16'hBEEF, 4'd7, 16'hBEEF, 1'b1);
        run_one("amt0", 3'd2, 16'h9A5C, 4'd0, 16'h9A5C, 1'b0);

        // Eight back-to-back ops, consumer stalls for three cycles mid-stream.
        for (int i = 0; i < 8; i++) begin
            op_a[i]  = 3'($urandom_range(0, 4));
            src_a[i] = 16'($urandom);
            amt_a[i] = 4'($urandom);
        end
        n0 = n_out; n_stall = 0; idx = 0;
        for (int c = 0; c < 40 && (idx < 8 || sb.size() > 0); c++) begin
            ordy = !(c >= 5 && c <= 7);
            if (idx < 8) step(1'b1, op_a[idx], src_a[idx], amt_a[idx], 4'(idx), ordy, 1'b0);
            else idle(ordy);
            if (last_acc) idx++;
        end
        chk("b2b_count", n_out - n0, 32'd8);
        chk("b2b_stall_cycles", n_stall, 32'd3);
        drain();

        // Flush with three ops in flight and a fourth presented in the flush cycle.
        for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 16'h0F0F, 4'(i + 1), 4'(i), 1'b1, 1'b0);
        step(1'b1, 3'd1, 16'hFFFF, 4'd2, 4'd3, 1'b1, 1'b1);
        chk("flush_not_accepted", {31'd0, last_acc}, 32'd0);
        n0 = n_out;
        for (int i = 0; i < 8; i++) idle(1'b1);
        chk("flush_no_out", n_out - n0, 32'd0);
        run_one("post_flush", 3'd2, 16'hA5A5, 4'd5, ref_shift(3'd2, 16'hA5A5, 4'd5), 1'b0);

        // Reset with ops in flight and the output stalled.
        for (int i = 0; i < 6; i++) step(1'b1, 3'd0, 16'h00FF, 4'd4, 4'(i + 5), 1'b0, 1'b0);
        chk("pre_reset_stalled", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_res", {16'd0, out_res}, 32'd0);
        chk("midrst_tag", {28'd0, out_tag}, 32'd0);
        chk("midrst_err", {31'd0, out_err}, 32'd0);
        sb.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst_in_ready", {31'd0, in_ready}, 32'd1);
        run_one("post_reset", 3'd1, 16'hC3C3, 4'd6, ref_shift(3'd1, 16'hC3C3, 4'd6), 1'b0);

        // Random traffic with random backpressure and occasional flush.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
                 4'($urandom), 4'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 29) == 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined barrel shifter/rotator for the execute stage. Successor to the 16-bit combinational left shifter: generalises width, adds logical/arithmetic right shifts and rotates, and registers one shift-amount bit per stage with a valid/ready handshake, stall and flush. It sits between decode operand muxing and execute writeback, and frees the ALU critical path of the log-depth shift mux chain.

## Interface
- WIDTH, 16, operand width; power of two, ≥ 4.
- TAG_W, 4, width of sideband tag carried alongside each operation (e.g. destination register).
- SHAMT_W, $clog2(WIDTH), derived localparam, not overridable.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  operation presented.
- in_ready  out  1  block accepts operation this cycle.
- in_op  in  3  operation code (see Operation).
- in_src  in  WIDTH  operand.
- in_amt  in  SHAMT_W  shift/rotate amount.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_res  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.
- out_err  out  1  reserved opcode was issued.

## Operation
- Opcodes: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101–111 reserved.
- Reserved opcode: out_res = in_src unmodified, out_err = 1; otherwise out_err = 0.
- Stage k (k = 0..SHAMT_W-1) shifts by 2^k when amt[k] = 1, else passes through; each stage output registered with its valid, op, remaining amt bits, tag.
- SLL/SRL zero-fill; SRA fills with the operand MSB; ROL/ROR wrap bits around.
- Amount 0: result equals operand for every opcode.
- Handshake: transfer on in_valid && in_ready; result consumed on out_valid && out_ready.
- stall = out_valid && !out_ready; when stall, every stage holds (valids, data, tags).
- in_ready = !stall && !flush (combinational).
- Bubbles do not collapse; pipeline advances as a unit.
- flush: all stage valids and out_valid cleared at next edge; input in the same cycle is not accepted; data registers may keep stale values.
- flush during stall: flush wins.
- Reset (any time, including mid-operation): all valids 0, out_res 0, out_tag 0, out_err 0; in_ready = 1 once rst_n deasserts.

## Timing
- Latency: SHAMT_W cycles from accept edge to out_valid (WIDTH=16: 4 cycles).
- Throughput: one operation per cycle with out_ready held high.
- Order preserved; no reordering, no drops except via flush/reset.
- A stall of N cycles delays every in-flight operation by exactly N cycles.
- out_* stable while out_valid && !out_ready.

## Configuration
- SHIFT_PIPE_ROTATE_EN defined: ROL and ROR implemented as above.
- Not defined: rotate logic omitted; 011 and 100 treated as reserved (pass-through, out_err = 1).

## Structure
- Shared package shift_pipe_pkg: op encoding constants (OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR), op typedef, reserved-opcode check function.
- One sub-module shift_stage: combinational single-step shifter, parameters WIDTH and STEP (2^k), inputs op, enable, data; instanced SHAMT_W times by generate, registers in the parent.

## Test plan
- WIDTH=16, SLL 0x0001 amt 15, out_ready=1 -> out_valid exactly 4 cycles after accept, out_res 0x8000, out_err 0.
- SRA 0x8000 amt 3 -> 0xF000; SRL 0x8000 amt 3 -> 0x1000; ROR 0x1234 amt 4 -> 0x4123 (with macro) / 0x1234 + out_err=1 (without).
- Back-to-back 8 ops with tags 0..7, out_ready low for 3 cycles mid-stream -> in_ready low during stall, all 8 results in order with correct tags, none duplicated.
- Opcode 110, src 0xBEEF -> out_res 0xBEEF, out_err 1.
- Three ops in flight, flush for one cycle with in_valid high -> no out_valid for those ops or the flushed-cycle input; next op accepted after flush completes normally.
- rst_n pulsed low with ops in flight and stall active -> out_valid, out_res, out_tag, out_err 0 immediately; in_ready 1 after release; first post-reset op correct.
